// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared constants for the 5-stage RISC-V hazard sequencer:
//   - RV32I major opcodes used by hazard decode (LOAD/STORE/OP/BRANCH/JAL/JALR)
//   - 2-bit FSM state encodings HZ_RUN / HZ_LOAD_STALL / HZ_CTRL_WAIT /
//     HZ_MEM_WAIT and the enum type built on them
//   - bundle type for the pipeline control strobes
//   - helper telling whether an opcode reads rs2
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic [1:0] HZ_RUN        = 2'd0;
    localparam logic [1:0] HZ_LOAD_STALL = 2'd1;
    localparam logic [1:0] HZ_CTRL_WAIT  = 2'd2;
    localparam logic [1:0] HZ_MEM_WAIT   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN        = HZ_RUN,
        ST_LOAD_STALL = HZ_LOAD_STALL,
        ST_CTRL_WAIT  = HZ_CTRL_WAIT,
        ST_MEM_WAIT   = HZ_MEM_WAIT
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
    } hz_ctrl_t;

    // Only BRANCH, STORE and OP carry a real rs2 operand; for other formats
    // the rs2 field is immediate bits and must not create a false hazard.
    function automatic logic opc_uses_rs2(input logic [6:0] opc);
        return (opc == OPCODE_BRANCH) || (opc == OPCODE_STORE) || (opc == OPCODE_OP);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_hazard_detect  (hazard_detect)
// Purely combinational hazard decode for the ID/EX stages.
//   i_id_valid, i_id_opc, i_id_rs1, i_id_rs2 : ID-stage instruction
//   i_ex_valid, i_ex_opc, i_ex_rd            : EX-stage instruction
//   o_load_use : EX holds a load whose rd (non-x0) is read by the ID instruction
//   o_is_ctrl  : ID holds a control-transfer instruction that freezes fetch
// Optional macro BRANCH_PREDICT_NT_EN: conditional branches are predicted
// not-taken and therefore no longer count as fetch-freezing control ops.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [6:0] i_id_opc,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic [6:0] i_ex_opc,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_use,
    output logic       o_is_ctrl
);

    logic w_uses_rs2;
    logic w_ex_load;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ctrl_opc;

    assign w_uses_rs2 = opc_uses_rs2(i_id_opc);

    // x0 is hard-wired zero, so a load into it never produces a dependency.
    assign w_ex_load  = i_ex_valid && (i_ex_opc == OPCODE_LOAD) && (i_ex_rd != 5'd0);
    assign w_rs1_hit  = (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = (i_id_rs2 == i_ex_rd) && w_uses_rs2;
    assign o_load_use = w_ex_load && i_id_valid && (w_rs1_hit || w_rs2_hit);

`ifdef BRANCH_PREDICT_NT_EN
    assign w_ctrl_opc = (i_id_opc == OPCODE_JAL) || (i_id_opc == OPCODE_JALR);
`else
    assign w_ctrl_opc = (i_id_opc == OPCODE_JAL) || (i_id_opc == OPCODE_JALR) ||
                        (i_id_opc == OPCODE_BRANCH);
`endif

    assign o_is_ctrl = i_id_valid && w_ctrl_opc;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// A registered FSM (RUN / LOAD_STALL / CTRL_WAIT / MEM_WAIT) with a stall
// down-counter; all outputs are combinational in state + current inputs.
//
// Parameters:
//   LOAD_STALL_CYC : total bubbles inserted on a load-use hazard (1..3)
//   CTRL_STALL_CYC : fetch-freeze cycles after a control op leaves ID (1..3)
//   CNT_W          : counter width, holds max(LOAD_STALL_CYC, CTRL_STALL_CYC)
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   id_valid, id_opc, id_rs1, id_rs2        : ID-stage instruction
//   ex_valid, ex_opc, ex_rd                 : EX-stage instruction
//   ex_branch_taken                         : EX redirect pulse
//   mem_busy                                : data memory not ready
//   pc_en, if_id_en, if_id_flush,
//   id_ex_flush, pipe_hold                  : pipeline control strobes
//   stall_active                            : FSM outside RUN
//
// Optional macro BRANCH_PREDICT_NT_EN: conditional branches are fetched
// not-taken; a taken branch resolved in EX flushes IF/ID and ID/EX for one
// cycle while the PC loads the target. JAL/JALR still use CTRL_WAIT.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CTRL_STALL_CYC = 2,
    parameter int CNT_W          = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] id_opc,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic [6:0] ex_opc,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       pipe_hold,
    output logic       stall_active
);

    // The detecting RUN cycle already delivers the first load bubble, so
    // LOAD_STALL only covers the remaining LOAD_STALL_CYC-1 cycles and is
    // skipped entirely for a single-bubble configuration.
    localparam bit              LOAD_NEEDS_STATE = (LOAD_STALL_CYC > 1);
    localparam logic [CNT_W-1:0] LOAD_CNT_INIT   =
        (LOAD_STALL_CYC > 1) ? CNT_W'(LOAD_STALL_CYC - 2) : '0;
    // CTRL_WAIT's cnt==0 cycle is the exit cycle (pc_en=1), so detect cycle
    // plus CTRL_STALL_CYC-1 wait cycles give CTRL_STALL_CYC frozen fetches.
    localparam logic [CNT_W-1:0] CTRL_CNT_INIT   = CNT_W'(CTRL_STALL_CYC - 1);

    hz_state_e        r_state;
    hz_state_e        r_ret;
    logic [CNT_W-1:0] r_cnt;

    logic     w_load_use;
    logic     w_is_ctrl;
    logic     w_redirect;
    logic     w_cnt_zero;
    logic     w_ctrl_exit;
    hz_ctrl_t w_ctrl;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_id_valid (id_valid),
        .i_id_opc   (id_opc),
        .i_id_rs1   (id_rs1),
        .i_id_rs2   (id_rs2),
        .i_ex_valid (ex_valid),
        .i_ex_opc   (ex_opc),
        .i_ex_rd    (ex_rd),
        .o_load_use (w_load_use),
        .o_is_ctrl  (w_is_ctrl)
    );

    // A taken branch redirect in RUN only exists with not-taken prediction;
    // otherwise branches are always waited out in CTRL_WAIT.
`ifdef BRANCH_PREDICT_NT_EN
    assign w_redirect = ex_branch_taken;
`else
    assign w_redirect = 1'b0;
`endif

    assign w_cnt_zero  = (r_cnt == '0);
    // Memory wait outranks leaving CTRL_WAIT; the exit is retried on return.
    assign w_ctrl_exit = !mem_busy && (ex_branch_taken || w_cnt_zero);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_ret   <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        r_state <= ST_MEM_WAIT;
                        r_ret   <= ST_RUN;
                    end else if (w_redirect) begin
                        // ID holds a wrong-path instruction being flushed;
                        // its hazards are irrelevant.
                        r_state <= ST_RUN;
                    end else if (w_load_use) begin
                        if (LOAD_NEEDS_STATE) begin
                            r_state <= ST_LOAD_STALL;
                            r_cnt   <= LOAD_CNT_INIT;
                        end
                    end else if (w_is_ctrl) begin
                        r_state <= ST_CTRL_WAIT;
                        r_cnt   <= CTRL_CNT_INIT;
                    end
                end
                ST_LOAD_STALL: begin
                    if (mem_busy) begin
                        r_state <= ST_MEM_WAIT;
                        r_ret   <= ST_LOAD_STALL;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CTRL_WAIT: begin
                    if (mem_busy) begin
                        r_state <= ST_MEM_WAIT;
                        r_ret   <= ST_CTRL_WAIT;
                    end else if (w_ctrl_exit) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // cnt is deliberately left untouched while waiting.
                    if (!mem_busy) begin
                        r_state <= r_ret;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_ctrl.pc_en       = 1'b1;
        w_ctrl.if_id_en    = 1'b1;
        w_ctrl.if_id_flush = 1'b0;
        w_ctrl.id_ex_flush = 1'b0;
        w_ctrl.pipe_hold   = 1'b0;
        if (!rst_n) begin
            w_ctrl.pc_en       = 1'b0;
            w_ctrl.if_id_en    = 1'b0;
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        // Normal strobes; the hold starts from MEM_WAIT.
                    end else if (w_redirect) begin
                        w_ctrl.if_id_flush = 1'b1;
                        w_ctrl.id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl.pc_en       = 1'b0;
                        w_ctrl.if_id_en    = 1'b0;
                        w_ctrl.id_ex_flush = 1'b1;
                    end else if (w_is_ctrl) begin
                        // Control op moves on to EX; the fetch behind it is squashed.
                        w_ctrl.pc_en       = 1'b0;
                        w_ctrl.if_id_flush = 1'b1;
                    end
                end
                ST_LOAD_STALL: begin
                    w_ctrl.pc_en       = 1'b0;
                    w_ctrl.if_id_en    = 1'b0;
                    w_ctrl.id_ex_flush = 1'b1;
                end
                ST_CTRL_WAIT: begin
                    // PC opens on the exit cycle so the redirect target loads.
                    w_ctrl.pc_en       = w_ctrl_exit;
                    w_ctrl.if_id_flush = 1'b1;
                end
                ST_MEM_WAIT: begin
                    w_ctrl.pc_en     = 1'b0;
                    w_ctrl.if_id_en  = 1'b0;
                    w_ctrl.pipe_hold = 1'b1;
                end
                default: begin
                    w_ctrl.pc_en = 1'b1;
                end
            endcase
        end
    end

    assign pc_en        = w_ctrl.pc_en;
    assign if_id_en     = w_ctrl.if_id_en;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign pipe_hold    = w_ctrl.pipe_hold;
    assign stall_active = rst_n && (r_state != ST_RUN);

endmodule
